// File: rtl/alarm_tone_gen_pkg.sv
// alarm_pkg: shared state type and counter-width helper for the alarm sounder.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } alarm_state_t;

    // Bits needed to hold any value in 0..value.
    function automatic int cnt_w(input int value);
        return $clog2(value + 1);
    endfunction

endpackage

// File: rtl/alarm_tone_gen_if.sv
// Trigger/abort inputs and buzzer/status outputs of the alarm sounder.
interface alarm_tone_gen_if;

    logic cronofin;
    logic stop;
    logic sonido;
    logic busy;
    logic done;

    modport master (output cronofin, stop, input sonido, busy, done);
    modport slave  (input cronofin, stop, output sonido, busy, done);

endinterface

// File: rtl/alarm_tone_gen_tone_divider.sv
// tone_divider: counts 0..TONE_HALF_CYC-1 while enabled and flags the terminal count.
module tone_divider
    import alarm_pkg::*;
#(
    parameter int TONE_HALF_CYC = 25000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int TW_RAW = cnt_w(TONE_HALF_CYC - 1);
    localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
    localparam logic [TW-1:0] TC = TW'(TONE_HALF_CYC - 1);

    logic [TW-1:0] cnt;

    // tick does not depend on clr, which keeps the FSM free of a combinational loop
    assign tick = en && (cnt == TC);

    // Half-period counter; clr wins over en so each burst restarts in phase.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + TW'(1);
        end
    end

endmodule

// File: rtl/alarm_tone_gen.sv
// alarm_tone_gen: burst/gap alarm sequencer driving the buzzer line.
// Optional feature macro: ALARM_RETRIGGER_EN (a new trigger restarts a running sequence).
//
// state | meaning
// IDLE  | silent, waiting for a cronofin rising edge
// TONE  | square wave on sonido for BEEP_ON_CYC clocks
// GAP   | silent pause of BEEP_OFF_CYC clocks between bursts
module alarm_tone_gen
    import alarm_pkg::*;
#(
    parameter int TONE_HALF_CYC = 25000,
    parameter int BEEP_ON_CYC   = 25_000_000,
    parameter int BEEP_OFF_CYC  = 25_000_000,
    parameter int BEEP_COUNT    = 16
) (
    input logic            clk,
    input logic            rst,
    alarm_tone_gen_if.slave bus
);

    localparam int PW_ON  = cnt_w(BEEP_ON_CYC - 1);
    localparam int PW_OFF = cnt_w(BEEP_OFF_CYC - 1);
    localparam int PW_RAW = (PW_ON > PW_OFF) ? PW_ON : PW_OFF;
    localparam int PW     = (PW_RAW < 1) ? 1 : PW_RAW;
    localparam int BW_RAW = cnt_w(BEEP_COUNT - 1);
    localparam int BW     = (BW_RAW < 1) ? 1 : BW_RAW;

    localparam logic [PW-1:0] ON_TC   = PW'(BEEP_ON_CYC - 1);
    localparam logic [PW-1:0] OFF_TC  = PW'(BEEP_OFF_CYC - 1);
    localparam logic [BW-1:0] LAST_IX = BW'(BEEP_COUNT - 1);

    alarm_state_t  state, state_n;
    logic [PW-1:0] phase_cnt, phase_n;
    logic [BW-1:0] burst_ix, burst_n;
    logic          sonido_q, sonido_n;
    logic          done_q, done_n;
    logic          cronofin_q;
    logic          trig;
    logic          restart;
    logic          tone_tick;

    assign trig = bus.cronofin & ~cronofin_q;

    // Outside TONE the divider is held at zero; restart covers a retrigger inside TONE.
    tone_divider #(
        .TONE_HALF_CYC(TONE_HALF_CYC)
    ) u_tone_divider (
        .clk (clk),
        .rst (rst),
        .clr (restart || (state != TONE)),
        .en  (state == TONE),
        .tick(tone_tick)
    );

    // State, counters, registered outputs and the trigger edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            burst_ix   <= '0;
            sonido_q   <= 1'b0;
            done_q     <= 1'b0;
            cronofin_q <= 1'b0;
        end else begin
            state      <= state_n;
            phase_cnt  <= phase_n;
            burst_ix   <= burst_n;
            sonido_q   <= sonido_n;
            done_q     <= done_n;
            cronofin_q <= bus.cronofin;
        end
    end

    // Next-state logic: stop has priority over everything, including a trigger.
    always_comb begin
        state_n  = state;
        phase_n  = phase_cnt;
        burst_n  = burst_ix;
        sonido_n = sonido_q;
        done_n   = 1'b0;
        restart  = 1'b0;

        if (bus.stop) begin
            state_n  = IDLE;
            phase_n  = '0;
            burst_n  = '0;
            sonido_n = 1'b0;
        end else begin
`ifdef ALARM_RETRIGGER_EN
            restart = trig;
`else
            restart = trig && (state == IDLE);
`endif
            if (restart) begin
                state_n  = TONE;
                phase_n  = '0;
                burst_n  = '0;
                sonido_n = 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        sonido_n = 1'b0;
                    end
                    TONE: begin
                        if (phase_cnt == ON_TC) begin
                            phase_n  = '0;
                            sonido_n = 1'b0;
                            if (burst_ix == LAST_IX) begin
                                state_n = IDLE;
                                burst_n = '0;
                                done_n  = 1'b1;
                            end else begin
                                state_n = GAP;
                            end
                        end else begin
                            phase_n = phase_cnt + PW'(1);
                            if (tone_tick) begin
                                sonido_n = ~sonido_q;
                            end
                        end
                    end
                    GAP: begin
                        sonido_n = 1'b0;
                        if (phase_cnt == OFF_TC) begin
                            state_n  = TONE;
                            phase_n  = '0;
                            burst_n  = burst_ix + BW'(1);
                            sonido_n = 1'b1;
                        end else begin
                            phase_n = phase_cnt + PW'(1);
                        end
                    end
                    default: begin
                        state_n  = IDLE;
                        phase_n  = '0;
                        burst_n  = '0;
                        sonido_n = 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sonido = sonido_q;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Directed bench for alarm_tone_gen with short cadence parameters.
module tb_alarm_tone_gen;

    localparam int HALF  = 2;
    localparam int ON    = 8;
    localparam int OFF   = 4;
    localparam int COUNT = 3;
    localparam int BUSY_LEN = COUNT * ON + (COUNT - 1) * OFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;

    alarm_tone_gen_if bus ();

    alarm_tone_gen #(
        .TONE_HALF_CYC(HALF),
        .BEEP_ON_CYC  (ON),
        .BEEP_OFF_CYC (OFF),
        .BEEP_COUNT   (COUNT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Expected sonido for cycle j (1-based) after the trigger cycle.
    function automatic logic exp_sonido(input int j);
        int p;
        int q;
        p = j - 1;
        q = p % (ON + OFF);
        if (q >= ON) return 1'b0;
        return ((q / HALF) % 2) == 0;
    endfunction

    // Caller has already driven the trigger for the coming edge.
    task automatic check_full_sequence(input string tag);
        for (int j = 1; j <= BUSY_LEN; j++) begin
            step();
            chk({tag, "_busy"}, bus.busy, 1'b1);
            chk({tag, "_sonido"}, bus.sonido, exp_sonido(j));
            chk({tag, "_nodone"}, bus.done, 1'b0);
        end
        step();
        chk({tag, "_done"}, bus.done, 1'b1);
        chk({tag, "_endbusy"}, bus.busy, 1'b0);
        chk({tag, "_endsonido"}, bus.sonido, 1'b0);
        step();
        chk({tag, "_donepulse"}, bus.done, 1'b0);
    endtask

    initial begin
        int done_at;
        int done_cnt;
        int exp_done_at;

        bus.cronofin = 1'b1;
        bus.stop     = 1'b0;
        rst          = 1'b1;

        // Reset held with cronofin high: outputs quiet, sequence starts right after.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_sonido", bus.sonido, 1'b0);
            chk("rst_busy", bus.busy, 1'b0);
            chk("rst_done", bus.done, 1'b0);
        end
        rst = 1'b0;
        check_full_sequence("rst_seq");

        // Level hold: cronofin still high, no second sequence.
        done_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (bus.done || bus.busy) done_cnt++;
        end
        chk_int("level_hold_idle", done_cnt, 0);

        // Full sequence from a clean 0->1 edge.
        bus.cronofin = 1'b0;
        step();
        step();
        bus.cronofin = 1'b1;
        check_full_sequence("full");
        bus.cronofin = 1'b0;
        step();

        // Abort inside the first gap (relative cycle 10).
        bus.cronofin = 1'b1;
        step();
        bus.cronofin = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("abort_pre_busy", bus.busy, 1'b1);
        chk("abort_pre_gap", bus.sonido, 1'b0);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_sonido", bus.sonido, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.done || bus.busy || bus.sonido) done_cnt++;
        end
        chk_int("abort_quiet", done_cnt, 0);

        // Stop and trigger in the same cycle: trigger discarded.
        bus.cronofin = 1'b1;
        bus.stop     = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("simul_busy", bus.busy, 1'b0);
        chk("simul_sonido", bus.sonido, 1'b0);
        step();
        step();
        chk("simul_busy_later", bus.busy, 1'b0);
        bus.cronofin = 1'b0;
        step();

        // Retrigger at relative cycle 15.
        bus.cronofin = 1'b1;
        step();
        bus.cronofin = 1'b0;
        for (int i = 0; i < 14; i++) step();
        bus.cronofin = 1'b1;
        step();
        bus.cronofin = 1'b0;
        chk("retrig_busy", bus.busy, 1'b1);
`ifdef ALARM_RETRIGGER_EN
        chk("retrig_sonido", bus.sonido, 1'b1);
        exp_done_at = 48;
`else
        chk("retrig_sonido", bus.sonido, 1'b0);
        exp_done_at = 33;
`endif
        done_at  = -1;
        done_cnt = 0;
        for (int rel = 17; rel <= 70; rel++) begin
            step();
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = rel;
            end
        end
        chk_int("retrig_done_cycle", done_at, exp_done_at);
        chk_int("retrig_done_count", done_cnt, 1);
        chk("retrig_end_busy", bus.busy, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alarm_tone_gen.md
# alarm_tone_gen

Parametrised alarm sounder for the chronometer datapath. A rising edge on `cronofin` (timer-expired flag) starts a sequence of `BEEP_COUNT` tone bursts separated by silent gaps. Each burst is a square wave of programmable pitch on `sonido`, the line that drives the board buzzer. The block adds abort, busy/done status and burst/gap cadence, and all timing is set by parameters.

## Interface
- `TONE_HALF_CYC`, default 25000: clocks per half-period of the tone (2 kHz at 100 MHz); must be ≥1.
- `BEEP_ON_CYC`, default 25_000_000: clocks per tone burst; must be ≥1.
- `BEEP_OFF_CYC`, default 25_000_000: clocks per silent gap between bursts; must be ≥1.
- `BEEP_COUNT`, default 16: bursts per sequence; must be ≥1.
- Counter widths are derived with `$clog2` of each value; they are not user parameters.

Ports:
- `clk` input 1: single system clock.
- `rst` input 1: reset; synchronous and active-high.
- `cronofin` input 1: trigger level; a rising edge starts the sequence.
- `stop` input 1: synchronous abort, active-high.
- `sonido` output 1: buzzer drive, registered.
- `busy` output 1: high while a sequence is running.
- `done` output 1: one-cycle pulse when a sequence completes normally.

## Operation
- **Reset values:**
  - `sonido`=0, `busy`=0, `done`=0.
  - State IDLE; all counters 0.
  - Edge-detect register = 0, so a `cronofin` held high through reset triggers on the first cycle after reset.
- **Edge detection:** `trig` = `cronofin` & ~`cronofin_q`. `cronofin_q` is updated every cycle.
- **States:** IDLE, TONE, GAP.
- **IDLE:**
  - `sonido`=0.
  - On `trig` (and no `stop`): go to TONE, `busy`=1, burst index=0, tone and phase counters=0, `sonido`=1.
- **TONE:**
  - Tone counter counts 0..`TONE_HALF_CYC`-1. At the terminal count it wraps to 0 and `sonido` inverts.
  - Phase counter counts 0..`BEEP_ON_CYC`-1. At the terminal count:
    - If burst index = `BEEP_COUNT`-1: go to IDLE, `sonido`=0, `busy`=0, `done`=1 for that one cycle.
    - Otherwise: go to GAP, `sonido`=0, phase counter=0.
- **GAP:**
  - `sonido`=0.
  - Phase counter counts 0..`BEEP_OFF_CYC`-1. At the terminal count: go to TONE, burst index+1, tone counter=0, `sonido`=1.
- **stop:**
  - In any state, the next cycle has IDLE, `sonido`=0, `busy`=0, and no `done`.
  - `stop` together with `trig` in the same cycle: `stop` wins and the trigger is discarded.
- **`trig` while busy:** behaviour depends on Configuration.
- **Tone phase per burst:** every burst starts with `sonido`=1. The tone phase never carries over from one burst to the next.
- **Counter arithmetic:** all counters are unsigned and compared with `==` against the terminal value. Counters never exceed their terminal value.

## Timing
- Let `trig` occur in cycle n.
  - `busy`=1 and `sonido`=1 from cycle n+1.
  - The first burst occupies cycles n+1 .. n+`BEEP_ON_CYC`.
- Total `busy` length: `BEEP_COUNT`·`BEEP_ON_CYC` + (`BEEP_COUNT`-1)·`BEEP_OFF_CYC` cycles.
- `done` is asserted in the first cycle in which `busy`=0 after a completed sequence.
- `stop` asserted in cycle m: `sonido`=0 and `busy`=0 in cycle m+1.
- A new `trig` is accepted in the same cycle that `done` is high.

## Configuration
- `ALARM_RETRIGGER_EN` defined:
  - A `trig` in TONE or GAP restarts the sequence: burst index=0, counters=0, state TONE, `sonido`=1 next cycle.
  - `busy` stays high throughout; no `done` is issued for the interrupted sequence.
- `ALARM_RETRIGGER_EN` undefined: `trig` while `busy`=1 is ignored.

## Structure
- Package `alarm_pkg` holds:
  - the state typedef `alarm_state_t` (IDLE, TONE, GAP);
  - the function `cnt_w(value)` returning `$clog2(value+1)`.
- Sub-module `tone_divider`:
  - inputs: `clk`, `rst`, `clr`, `en`;
  - output: a `tick` at terminal count;
  - parameter: `TONE_HALF_CYC`.
  - The top-level FSM toggles `sonido` on `tick`.

## Test plan
All scenarios use `TONE_HALF_CYC`=2, `BEEP_ON_CYC`=8, `BEEP_OFF_CYC`=4, `BEEP_COUNT`=3.
- **Full sequence:** `cronofin` 0→1 at cycle 10.
  - `busy` is high in cycles 11–42.
  - `sonido` is 1,1,0,0,1,1,0,0 in cycles 11–18, then 0 in cycles 19–22, then the burst pattern repeats.
  - `done`=1 in cycle 43 only.
- **Reset:** hold `rst` for 3 cycles with `cronofin`=1, then release.
  - All outputs are 0 during reset.
  - The sequence starts in the first cycle after reset.
- **Abort:** `stop`=1 in cycle 20 (inside the GAP).
  - `sonido`=0 and `busy`=0 from cycle 21.
  - `done` is never asserted.
- **Simultaneous stop and trigger:** `stop` and the `cronofin` edge in the same cycle.
  - The block stays IDLE and `busy` stays 0.
- **Retrigger:** second `cronofin` edge at cycle 25, with `cronofin` held low after the first edge and raised again at cycle 25.
  - With `ALARM_RETRIGGER_EN`: a burst restarts at cycle 26 with `sonido`=1, and `done` occurs at cycle 58.
  - Without it: no effect, and `done` occurs at cycle 43.
- **Level hold:** `cronofin` held high for 100 cycles produces exactly one sequence and one `done` pulse.
